// File: rtl/m10k_port_arbiter.sv
// rtl/m10k_port_arbiter.sv - two-requester arbiter in front of one 256x8 M10K block
//
// Shares one simple-dual-port M10K (one write port, one synchronous read port,
// one-cycle read latency) between requester 0 and requester 1. At most one
// access is granted per cycle. A requester may lock ownership for a burst of
// up to MAX_BURST consecutive grants. Memory-side outputs are registered.
// Read data is returned on the shared rdata bus, qualified by the per-requester
// rvalid, two cycles after the grant.
//
// Optional build macro: M10K_ARB_FIXED_PRIO_EN
//   defined   - idle arbitration always favours requester 0
//   undefined - round-robin against the last granted requester
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   rN_req/we/lock/addr/wdata     requester N access request
//   rN_gnt                        combinational grant for requester N
//   rN_rvalid                     read data on rdata belongs to requester N
//   rdata                         shared read data (passthrough of mem_q)
//   mem_we/waddr/d                registered M10K write port
//   mem_raddr                     registered M10K read address
//   mem_q                         M10K read data

module m10k_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] bcnt, bcnt_nxt;
  logic [7:0] bcnt_inc;

  logic              any_gnt;
  logic              win;        // winning requester id
  logic              win_we;
  logic              win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              owner_hold; // current lock owner is requesting again
  logic              pick1;      // idle-rule arbitration picks requester 1

  // Read tag pipeline: stage 1 tracks the cycle mem_raddr is presented,
  // stage 2 lines up with mem_q.
  logic v1, v2;
  logic t1, t2;

  assign bcnt_inc = bcnt + 8'd1;

  assign owner_hold = ((state == OWN0) && r0_req) || ((state == OWN1) && r1_req);

`ifdef M10K_ARB_FIXED_PRIO_EN
  assign pick1 = r1_req && !r0_req;
`else
  // Both requesting: take the one that did not win last time.
  assign pick1 = r1_req && (!r0_req || !last);
`endif

  assign win_we    = win ? r1_we    : r0_we;
  assign win_lock  = win ? r1_lock  : r0_lock;
  assign win_addr  = win ? r1_addr  : r0_addr;
  assign win_wdata = win ? r1_wdata : r0_wdata;

  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    bcnt_nxt  = 8'd0;
    any_gnt   = 1'b0;
    win       = 1'b0;

    if (!reset) begin
      if (owner_hold) begin
        // Locked owner keeps the port regardless of the other requester.
        win      = (state == OWN1);
        any_gnt  = 1'b1;
        last_nxt = win;
        if (win_lock && (bcnt_inc != BURST_CAP)) begin
          state_nxt = state;
          bcnt_nxt  = bcnt_inc;
        end
      end else if (r0_req || r1_req) begin
        // Idle, or the owner dropped its request: arbitrate this cycle.
        win      = pick1;
        any_gnt  = 1'b1;
        last_nxt = win;
        // A cap of one means a lock can never extend past the first grant.
        if (win_lock && (BURST_CAP != 8'd1)) begin
          state_nxt = win ? OWN1 : OWN0;
          bcnt_nxt  = 8'd1;
        end
      end
    end
  end

  assign r0_gnt = any_gnt && !win;
  assign r1_gnt = any_gnt &&  win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b0;
      bcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_raddr <= '0;
      mem_d     <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      t1        <= 1'b0;
      t2        <= 1'b0;
    end else begin
      mem_we <= any_gnt && win_we;
      if (any_gnt && win_we) begin
        mem_waddr <= win_addr;
        mem_d     <= win_wdata;
      end
      // Read address holds between reads so the M10K output stays stable.
      if (any_gnt && !win_we) begin
        mem_raddr <= win_addr;
      end
      v1 <= any_gnt && !win_we;
      t1 <= win;
      v2 <= v1;
      t2 <= t1;
    end
  end

  assign rdata     = mem_q;
  assign r0_rvalid = v2 && !t2;
  assign r1_rvalid = v2 &&  t2;

endmodule

// File: tb/tb_m10k_port_arbiter.sv
// tb/tb_m10k_port_arbiter.sv - scoreboard bench for m10k_port_arbiter

module tb_m10k_port_arbiter;

`ifdef M10K_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       r0_req, r0_we, r0_lock;
  logic [7:0] r0_addr, r0_wdata;
  logic       r1_req, r1_we, r1_lock;
  logic [7:0] r1_addr, r1_wdata;
  logic       r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [7:0] rdata;
  logic       mem_we;
  logic [7:0] mem_waddr, mem_raddr, mem_d, mem_q;

  m10k_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_lock   (r0_lock),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_lock   (r1_lock),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r0_gnt    (r0_gnt),
    .r1_gnt    (r1_gnt),
    .r0_rvalid (r0_rvalid),
    .r1_rvalid (r1_rvalid),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_d     (mem_d),
    .mem_q     (mem_q)
  );

  // M10K behavioural model
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_d;
    mem_q <= mem[mem_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks;
  int n_pass;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Monitor: pop one expectation per rvalid and compare id, data and cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (r0_rvalid === 1'b1 || r1_rvalid === 1'b1) begin
      chk("rvalid_onehot", {30'd0, r0_rvalid, r1_rvalid} == 32'd3, 32'd0);
      if (sbq.size() == 0) begin
        chk("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rd_id", {31'd0, r1_rvalid}, {31'd0, e.id});
        chk("rd_data", {24'd0, rdata}, {24'd0, e.data});
        chk("rd_cycle", cyc, e.at);
      end
    end
  end

  task automatic step(input logic q0, input logic w0, input logic l0,
                      input logic [7:0] a0, input logic [7:0] d0,
                      input logic q1, input logic w1, input logic l1,
                      input logic [7:0] a1, input logic [7:0] d1,
                      input logic eg0, input logic eg1, input logic [7:0] ed,
                      input string tag);
    exp_t e;
    @(negedge clk);
    r0_req = q0; r0_we = w0; r0_lock = l0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_lock = l1; r1_addr = a1; r1_wdata = d1;
    #1;
    chk({tag, "_g0"}, {31'd0, r0_gnt}, {31'd0, eg0});
    chk({tag, "_g1"}, {31'd0, r1_gnt}, {31'd0, eg1});
    if ((eg0 && !w0) || (eg1 && !w1)) begin
      e.id = eg1; e.data = ed; e.at = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 8'd0, tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rv0"},   {31'd0, r0_rvalid}, 32'd0);
    chk({tag, "_rv1"},   {31'd0, r1_rvalid}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, "_waddr"}, {24'd0, mem_waddr}, 32'd0);
    chk({tag, "_raddr"}, {24'd0, mem_raddr}, 32'd0);
    chk({tag, "_d"},     {24'd0, mem_d}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
    #1;
    chk("rst_gnt0", {31'd0, r0_gnt}, 32'd0);
    chk("rst_gnt1", {31'd0, r1_gnt}, 32'd0);
    @(negedge clk);
    r0_req = 1'b0; r1_req = 1'b0;
    #1;
    chk_reset_outputs("rst");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int  n0;
    bit  r1_done;
    bit  eg0, eg1;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    cyc = 0; n_checks = 0; n_pass = 0;
    reset = 1'b1;
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;

    // Write then read-back across requesters
    do_reset();
    step(1, 1, 0, 8'd3, 8'h05, 0, 0, 0, 8'd0, 8'd0, 1, 0, 8'd0, "t1_wr");
    step(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd3, 8'd0, 0, 1, 8'h05, "t1_rd");
    chk("t1_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t1_waddr", {24'd0, mem_waddr}, 32'd3);
    chk("t1_d", {24'd0, mem_d}, 32'h05);
    idle("t1_i0");
    chk("t1_we_off", {31'd0, mem_we}, 32'd0);
    chk("t1_raddr", {24'd0, mem_raddr}, 32'd3);
    idle("t1_i1");
    chk("t1_raddr_hold", {24'd0, mem_raddr}, 32'd3);
    step(1, 1, 0, 8'd4, 8'hA7, 0, 0, 0, 8'd0, 8'd0, 1, 0, 8'd0, "t1_wr4");
    idle("t1_i2");

    // Both reading continuously, no lock: round-robin starting with r1
    do_reset();
    for (int i = 0; i < 6; i++) begin
      eg0 = FIXED ? 1'b1 : (i % 2 == 1);
      eg1 = !eg0;
      step(1, 0, 0, 8'd3, 8'd0, 1, 0, 0, 8'd4, 8'd0, eg0, eg1,
           eg0 ? 8'h05 : 8'hA7, "t2_alt");
    end
    step(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd4, 8'd0, 0, 1, 8'hA7, "t2_r1only");
    idle("t2_i0");
    idle("t2_i1");

    // r0 locked 20-read stream against a waiting r1, cap 16
    do_reset();
    n0 = 0; r1_done = 0;
    for (int i = 0; i < 22; i++) begin
      eg1 = FIXED ? (i == 20) : (i == 16);
      eg0 = !eg1 && (n0 < 20);
      step(n0 < 20, 0, n0 < 19, 8'd3, 8'd0,
           (i >= 1) && !r1_done, 0, 0, 8'd4, 8'd0,
           eg0, eg1, eg0 ? 8'h05 : 8'hA7, "t3_burst");
      if (eg0) n0++;
      if (eg1) r1_done = 1;
    end
    idle("t3_i0");
    idle("t3_i1");

    // Fill 0..16 with 1, read back 0..17, then read-after-write
    for (int a = 0; a <= 16; a++)
      step(1, 1, 0, 8'(a), 8'h01, 0, 0, 0, 8'd0, 8'd0, 1, 0, 8'd0, "t4_fill");
    for (int a = 0; a <= 17; a++)
      step(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'(a), 8'd0, 0, 1,
           (a <= 16) ? 8'h01 : 8'h00, "t4_rd");
    step(1, 1, 0, 8'd20, 8'h5C, 0, 0, 0, 8'd0, 8'd0, 1, 0, 8'd0, "t4_raw_wr");
    step(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd20, 8'd0, 0, 1, 8'h5C, "t4_raw_rd");
    idle("t4_i0");
    idle("t4_i1");
    idle("t4_i2");

    // Reset one cycle after a read grant drops the pending read
    @(negedge clk);
    r1_req = 1; r1_we = 0; r1_addr = 8'd5;
    #1;
    chk("t5_gnt", {31'd0, r1_gnt}, 32'd1);
    @(negedge clk);
    r1_req = 0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("t5");
    reset = 1'b0;
    step(1, 0, 0, 8'd20, 8'd0, 1, 0, 0, 8'd0, 8'd0, FIXED, !FIXED,
         FIXED ? 8'h5C : 8'h01, "t5_after");
    idle("t5_i0");
    idle("t5_i1");
    idle("t5_i2");
    idle("t5_i3");

    chk("sb_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
